// File: rtl/draw_sequencer_if.sv
// Bundles the request side (from game logic) and the drawer-facing outputs
// of the draw sequencer.
//   master : the requester / observer (drives requests and digits, sees drawer outputs)
//   slave  : the sequencer itself
// Signals:
//   lane_req[3:0], lane_on[3:0]  lane redraw pulse and colour (1 = white)
//   score_req[1:0]               score glyph redraw pulse, player 0/1
//   score0[3:0], score1[3:0]     player hex digits
//   x[7:0], y[7:0]               origin to drawer
//   draw[5:0]                    one-hot job select
//   plot, black, score[3:0]      drawer advance, square colour, glyph digit
//   busy, done                   sequencer status, job-complete pulse
interface draw_sequencer_if;
    logic [3:0] lane_req;
    logic [3:0] lane_on;
    logic [1:0] score_req;
    logic [3:0] score0;
    logic [3:0] score1;
    logic [7:0] x;
    logic [7:0] y;
    logic [5:0] draw;
    logic       plot;
    logic       black;
    logic [3:0] score;
    logic       busy;
    logic       done;

    modport master (
        output lane_req, lane_on, score_req, score0, score1,
        input  x, y, draw, plot, black, score, busy, done
    );

    modport slave (
        input  lane_req, lane_on, score_req, score0, score1,
        output x, y, draw, plot, black, score, busy, done
    );
endinterface

// File: rtl/draw_sequencer.sv
// Upstream controller for the square/score pixel drawer. Latches lane-square
// and score-glyph redraw requests, serialises them lowest-index first and
// drives the drawer for exactly its pixel-cycle count per job, dropping draw
// between jobs so the drawer's counters clear.
// Ports:
//   clock   system clock, rising edge
//   resetn  asynchronous active-low reset
//   seq_if  draw_sequencer_if.slave (requests in, drawer controls out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no job; grant lowest pending request if any
// LOAD  | draw/x/y/black/score presented, plot low, counter cleared
// PLOT  | plot high for SQ_CYCLES (lane) or GLYPH_CYCLES (score) cycles
// CLEAR | draw and plot low, done pulse, back to IDLE
module draw_sequencer #(
    parameter int unsigned SQ_CYCLES    = 16,
    parameter int unsigned GLYPH_CYCLES = 75,
    parameter logic [7:0]  LANE_X0      = 8'd20,
    parameter logic [7:0]  LANE_X1      = 8'd40,
    parameter logic [7:0]  LANE_X2      = 8'd60,
    parameter logic [7:0]  LANE_X3      = 8'd80,
    parameter logic [7:0]  LANE_Y       = 8'd100,
    parameter logic [7:0]  SCORE_X0     = 8'd10,
    parameter logic [7:0]  SCORE_X1     = 8'd130,
    parameter logic [7:0]  SCORE_Y      = 8'd5
) (
    input  logic             clock,
    input  logic             resetn,
    draw_sequencer_if.slave  seq_if
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PLOT  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam logic [6:0] SQ_LAST    = 7'(SQ_CYCLES - 1);
    localparam logic [6:0] GLYPH_LAST = 7'(GLYPH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [5:0] pending_q, pending_d;
    logic [3:0] on_latch_q, on_latch_d;
    logic [6:0] cnt_q, cnt_d;
    logic [5:0] grant_q, grant_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic       black_q, black_d;
    logic [3:0] score_q, score_d;

    logic [5:0] grant_lo;
    logic [5:0] clr;
    logic [6:0] cnt_last;

    // Isolate the lowest set pending bit (two's complement trick).
    assign grant_lo = pending_q & (~pending_q + 6'd1);
    assign cnt_last = (|grant_q[5:4]) ? GLYPH_LAST : SQ_LAST;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            on_latch_q <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            black_q    <= 1'b0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            on_latch_q <= on_latch_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            x_q        <= x_d;
            y_q        <= y_d;
            black_q    <= black_d;
            score_q    <= score_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        x_d        = x_q;
        y_d        = y_q;
        black_d    = black_q;
        score_d    = score_q;
        clr        = '0;
        on_latch_d = on_latch_q;

        for (int i = 0; i < 4; i++) begin
            if (seq_if.lane_req[i]) begin
                on_latch_d[i] = seq_if.lane_on[i];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    clr     = grant_lo;
                    grant_d = grant_lo;
                    state_d = S_LOAD;
                    case (grant_lo)
                        6'b000001: begin x_d = LANE_X0; y_d = LANE_Y; black_d = ~on_latch_q[0]; end
                        6'b000010: begin x_d = LANE_X1; y_d = LANE_Y; black_d = ~on_latch_q[1]; end
                        6'b000100: begin x_d = LANE_X2; y_d = LANE_Y; black_d = ~on_latch_q[2]; end
                        6'b001000: begin x_d = LANE_X3; y_d = LANE_Y; black_d = ~on_latch_q[3]; end
                        6'b010000: begin
                            x_d     = SCORE_X0;
                            y_d     = SCORE_Y;
                            black_d = 1'b0;
                            score_d = seq_if.score0;
                        end
                        6'b100000: begin
                            x_d     = SCORE_X1;
                            y_d     = SCORE_Y;
                            black_d = 1'b0;
                            score_d = seq_if.score1;
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_PLOT;
            end
            S_PLOT: begin
                if (cnt_q == cnt_last) begin
                    state_d = S_CLEAR;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A request arriving on its own grant edge survives the clear.
        pending_d = (pending_q & ~clr) | {seq_if.score_req, seq_if.lane_req};
    end

    assign seq_if.draw  = (state_q == S_LOAD || state_q == S_PLOT) ? grant_q : 6'd0;
    assign seq_if.plot  = (state_q == S_PLOT);
    assign seq_if.busy  = (state_q != S_IDLE);
    assign seq_if.done  = (state_q == S_CLEAR);
    assign seq_if.x     = x_q;
    assign seq_if.y     = y_q;
    assign seq_if.black = black_q;
    assign seq_if.score = score_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Testbench for draw_sequencer: a table of single-job vectors plus
// hand-written sequences for priority ordering, coalescing, set-beats-clear,
// asynchronous reset mid-glyph and score-input changes during PLOT.
module tb_draw_sequencer;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    draw_sequencer_if bus();

    draw_sequencer dut (
        .clock  (clock),
        .resetn (resetn),
        .seq_if (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [3:0] lreq;
        logic [3:0] lon;
        logic [1:0] sreq;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [5:0] draw;
        logic [7:0] x;
        logic [7:0] y;
        logic       black;
        logic       chk_score;
        logic [3:0] score;
        int         plots;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic [3:0] lreq, input logic [3:0] lon, input logic [1:0] sreq);
        bus.lane_req  = lreq;
        bus.lane_on   = lon;
        bus.score_req = sreq;
        tick();
        bus.lane_req  = '0;
        bus.score_req = '0;
    endtask

    // Waits (bounded) for the next LOAD, checks presented fields, counts plot
    // cycles, checks the hold, the CLEAR cycle and the following IDLE cycle.
    task automatic expect_job(input string tag, input logic [5:0] draw, input logic [7:0] x,
                              input logic [7:0] y, input logic black, input logic chk_score,
                              input logic [3:0] score, input int plots);
        int         waitc;
        int         n;
        logic       held;
        logic [5:0] d0;
        logic [7:0] x0, y0;
        logic       b0;
        logic [3:0] s0;
        waitc = 0;
        while (bus.draw == 6'd0 && waitc < 20) begin
            tick();
            waitc++;
        end
        chk({tag, " start"}, 32'(bus.draw != 6'd0), 32'd1);
        if (bus.draw == 6'd0) return;
        chk({tag, " draw"}, 32'(bus.draw), 32'(draw));
        chk({tag, " x"}, 32'(bus.x), 32'(x));
        chk({tag, " y"}, 32'(bus.y), 32'(y));
        chk({tag, " black"}, 32'(bus.black), 32'(black));
        chk({tag, " load_plot"}, 32'(bus.plot), 32'd0);
        if (chk_score) chk({tag, " score"}, 32'(bus.score), 32'(score));
        d0 = bus.draw; x0 = bus.x; y0 = bus.y; b0 = bus.black; s0 = bus.score;
        held = 1'b1;
        n = 0;
        tick();
        while (bus.plot && n < 200) begin
            n++;
            if (bus.draw !== d0 || bus.x !== x0 || bus.y !== y0 ||
                bus.black !== b0 || bus.score !== s0) held = 1'b0;
            tick();
        end
        chk({tag, " plots"}, 32'(n), 32'(plots));
        chk({tag, " hold"}, 32'(held), 32'd1);
        chk({tag, " clear_done"}, 32'(bus.done), 32'd1);
        chk({tag, " clear_draw"}, 32'(bus.draw), 32'd0);
        tick();
        chk({tag, " idle"}, 32'({bus.busy, bus.done, bus.plot, bus.draw}), 32'd0);
    endtask

    task automatic no_job(input string tag, input int ncyc);
        int seen;
        seen = 0;
        repeat (ncyc) begin
            tick();
            if (bus.busy || bus.draw != 6'd0) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"v_lane1_white", 4'b0010, 4'b0010, 2'b00, 4'h0, 4'h0, 6'd2,  8'd40,  8'd100, 1'b0, 1'b0, 4'h0, 16};
        vecs[1] = '{"v_lane3_erase", 4'b1000, 4'b0000, 2'b00, 4'h0, 4'h0, 6'd8,  8'd80,  8'd100, 1'b1, 1'b0, 4'h0, 16};
        vecs[2] = '{"v_lane0_white", 4'b0001, 4'b0001, 2'b00, 4'h0, 4'h0, 6'd1,  8'd20,  8'd100, 1'b0, 1'b0, 4'h0, 16};
        vecs[3] = '{"v_lane2_erase", 4'b0100, 4'b0000, 2'b00, 4'h0, 4'h0, 6'd4,  8'd60,  8'd100, 1'b1, 1'b0, 4'h0, 16};
        vecs[4] = '{"v_score1",      4'b0000, 4'b0000, 2'b10, 4'h0, 4'h5, 6'd32, 8'd130, 8'd5,   1'b0, 1'b1, 4'h5, 75};
        vecs[5] = '{"v_score0",      4'b0000, 4'b0000, 2'b01, 4'hC, 4'h0, 6'd16, 8'd10,  8'd5,   1'b0, 1'b1, 4'hC, 75};

        bus.lane_req  = '0;
        bus.lane_on   = '0;
        bus.score_req = '0;
        bus.score0    = '0;
        bus.score1    = '0;

        #12;
        chk("rst x",     32'(bus.x), 32'd0);
        chk("rst y",     32'(bus.y), 32'd0);
        chk("rst draw",  32'(bus.draw), 32'd0);
        chk("rst score", 32'(bus.score), 32'd0);
        chk("rst ctl",   32'({bus.plot, bus.black, bus.busy, bus.done}), 32'd0);
        resetn = 1'b1;
        no_job("rst no_job", 5);

        for (int i = 0; i < 6; i++) begin
            bus.score0 = vecs[i].s0;
            bus.score1 = vecs[i].s1;
            pulse(vecs[i].lreq, vecs[i].lon, vecs[i].sreq);
            expect_job(vecs[i].name, vecs[i].draw, vecs[i].x, vecs[i].y, vecs[i].black,
                       vecs[i].chk_score, vecs[i].score, vecs[i].plots);
        end

        // Simultaneous requests are served lane0, lane2, score0.
        bus.score0 = 4'hA;
        pulse(4'b0101, 4'b0100, 2'b01);
        expect_job("sim lane0", 6'd1, 8'd20, 8'd100, 1'b1, 1'b0, 4'h0, 16);
        expect_job("sim lane2", 6'd4, 8'd60, 8'd100, 1'b0, 1'b0, 4'h0, 16);
        expect_job("sim score0", 6'd16, 8'd10, 8'd5, 1'b0, 1'b1, 4'hA, 75);
        no_job("sim no_extra", 10);

        // Three lane1 pulses during a lane3 job coalesce into one job.
        fork
            begin
                pulse(4'b1000, 4'b0000, 2'b00);
                tick();
                for (int k = 0; k < 3; k++) begin
                    pulse(4'b0010, 4'b0010, 2'b00);
                    tick();
                end
            end
            begin
                expect_job("coal lane3", 6'd8, 8'd80, 8'd100, 1'b1, 1'b0, 4'h0, 16);
                expect_job("coal lane1", 6'd2, 8'd40, 8'd100, 1'b0, 1'b0, 4'h0, 16);
            end
        join
        no_job("coal no_extra", 30);

        // Lane1 pulsed again on its own grant edge: a second job follows.
        pulse(4'b0010, 4'b0010, 2'b00);
        pulse(4'b0010, 4'b0010, 2'b00);
        expect_job("sbc first", 6'd2, 8'd40, 8'd100, 1'b0, 1'b0, 4'h0, 16);
        expect_job("sbc second", 6'd2, 8'd40, 8'd100, 1'b0, 1'b0, 4'h0, 16);
        no_job("sbc no_extra", 30);

        // Score input change mid-PLOT is ignored.
        bus.score0 = 4'h3;
        fork
            begin
                pulse(4'b0000, 4'b0000, 2'b01);
                repeat (12) tick();
                bus.score0 = 4'h7;
            end
            expect_job("schg", 6'd16, 8'd10, 8'd5, 1'b0, 1'b1, 4'h3, 75);
        join

        // Asynchronous reset in the middle of a glyph, with a lane request pending.
        bus.score1 = 4'h9;
        pulse(4'b0000, 4'b0000, 2'b10);
        repeat (20) tick();
        chk("rstmid pre_plot", 32'(bus.plot), 32'd1);
        pulse(4'b0001, 4'b0001, 2'b00);
        #3;
        resetn = 1'b0;
        #1;
        chk("rstmid plot",  32'(bus.plot), 32'd0);
        chk("rstmid draw",  32'(bus.draw), 32'd0);
        chk("rstmid busy",  32'(bus.busy), 32'd0);
        chk("rstmid x",     32'(bus.x), 32'd0);
        chk("rstmid score", 32'(bus.score), 32'd0);
        @(posedge clock);
        #2;
        resetn = 1'b1;
        no_job("rstmid no_job", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
